rx_extract_ctrl: RTL and testbench



---
 rtl/rx_extract_ctrl_pkg.sv | 30 +++
 rtl/rx_word_skid.sv | 29 ++
 rtl/rx_extract_ctrl.sv | 166 ++++++++++++++++
 tb/tb_rx_extract_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_extract_ctrl_pkg.sv
// Shared definitions for the radix-4 extractor sequencer and its neighbouring
// ACS/traceback controllers: state encoding, symbol geometry, handshake helper.
package rx_extract_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_WORD,
    EXTRACT,
    DRAIN,
    TRACEBACK
  } ctrl_state_e;

  localparam int SYMS_PER_WORD = 8;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_SYM_W     = DEF_DATA_W / SYMS_PER_WORD;

  // Enable level shared by the extractor, ACS and traceback strobes.
  localparam logic EN_ON = 1'b1;

  function automatic int idx_width(input int frame_words, input int syms_per_word);
    int n;
    n = frame_words * syms_per_word;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic hs_fire(input logic valid, input logic ready);
    return valid & ready;
  endfunction

endpackage

// File: rtl/rx_word_skid.sv
// One-entry holding register for the next received word; used by
// rx_extract_ctrl only when RX_PREFETCH_EN is defined.
module rx_word_skid
  import rx_extract_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_take,
  output logic              o_full,
  output logic [DATA_W-1:0] o_data
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_full <= 1'b0;
      o_data <= '0;
    end else if (i_load) begin
      o_full <= 1'b1;
      o_data <= i_data;
    end else if (i_take) begin
      o_full <= 1'b0;
    end
  end

endmodule

// File: rtl/rx_extract_ctrl.sv
// Sequencer for the radix-4 bit extractor: word handshake, 8-cycle extract
// enable, ACS qualifiers and traceback hand-off. RX_PREFETCH_EN adds a skid word.
module rx_extract_ctrl
  import rx_extract_ctrl_pkg::*;
#(
  parameter int  DATA_W      = DEF_DATA_W,
  parameter int  SYM_W       = DEF_SYM_W,
  parameter int  FRAME_WORDS = 4,
  localparam int IDX_W       = idx_width(FRAME_WORDS, DATA_W / SYM_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_word,
  output logic              o_en_extract,
  output logic              o_en_acs,
  output logic [IDX_W-1:0]  o_sym_idx,
  output logic              o_frame_end,
  output logic              o_en_tb,
  input  logic              i_tb_done,
  output logic              o_busy
);

  localparam int SPW    = DATA_W / SYM_W;
  localparam int SUB_W  = (SPW > 1) ? $clog2(SPW) : 1;
  localparam int WCNT_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(SPW - 1);
  localparam logic [WCNT_W-1:0] WORD_LAST = WCNT_W'(FRAME_WORDS - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(FRAME_WORDS * SPW - 1);

`ifdef RX_PREFETCH_EN
  localparam logic PREFETCH = 1'b1;
`else
  localparam logic PREFETCH = 1'b0;
`endif

  ctrl_state_e       state;
  logic [SUB_W-1:0]  sub_cnt;
  logic [WCNT_W-1:0] word_cnt;
  logic [WCNT_W-1:0] word_cnt_inc;
  logic              fire;
  logic              sub_last;
  logic              word_last;
  logic              have_next;
  logic [DATA_W-1:0] next_word;

  assign fire         = hs_fire(i_valid, o_ready);
  assign sub_last     = (sub_cnt == SUB_LAST);
  assign word_last    = (word_cnt == WORD_LAST);
  assign word_cnt_inc = word_cnt + 1'b1;

`ifdef RX_PREFETCH_EN
  logic              skid_full;
  logic              skid_load;
  logic              skid_take;
  logic [DATA_W-1:0] skid_data;

  // A word arriving on the last extract cycle bypasses the skid straight into o_word.
  assign skid_load = fire && (state == EXTRACT) && !sub_last;
  assign skid_take = (state == EXTRACT) && sub_last && skid_full;
  assign have_next = skid_full || (fire && (state == EXTRACT));
  assign next_word = skid_full ? skid_data : i_data;

  rx_word_skid #(.DATA_W(DATA_W)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .i_load (skid_load),
    .i_data (i_data),
    .i_take (skid_take),
    .o_full (skid_full),
    .o_data (skid_data)
  );
`else
  assign have_next = 1'b0;
  assign next_word = i_data;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      sub_cnt      <= '0;
      word_cnt     <= '0;
      o_ready      <= 1'b0;
      o_word       <= '0;
      o_en_extract <= 1'b0;
      o_en_acs     <= 1'b0;
      o_sym_idx    <= '0;
      o_frame_end  <= 1'b0;
      o_en_tb      <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      // The extractor registers o_Rx, so ACS qualifiers trail the enable by one cycle.
      o_en_acs    <= o_en_extract;
      o_frame_end <= 1'b0;
      if (o_en_acs) begin
        o_sym_idx <= (o_sym_idx == IDX_LAST) ? '0 : o_sym_idx + 1'b1;
      end

      case (state)
        IDLE: begin
          if (i_start) begin
            state     <= WAIT_WORD;
            word_cnt  <= '0;
            o_sym_idx <= '0;
            o_ready   <= 1'b1;
            o_busy    <= 1'b1;
          end
        end

        WAIT_WORD: begin
          if (fire) begin
            state        <= EXTRACT;
            o_word       <= i_data;
            sub_cnt      <= '0;
            o_en_extract <= EN_ON;
            o_ready      <= PREFETCH && !word_last;
          end
        end

        EXTRACT: begin
          if (!sub_last) begin
            sub_cnt <= sub_cnt + 1'b1;
            o_ready <= PREFETCH && !have_next && !word_last;
          end else begin
            sub_cnt <= '0;
            if (word_last) begin
              state        <= DRAIN;
              o_en_extract <= 1'b0;
              o_ready      <= 1'b0;
              o_frame_end  <= 1'b1;
            end else if (have_next) begin
              word_cnt <= word_cnt_inc;
              o_word   <= next_word;
              o_ready  <= PREFETCH && (word_cnt_inc != WORD_LAST);
            end else begin
              state        <= WAIT_WORD;
              word_cnt     <= word_cnt_inc;
              o_en_extract <= 1'b0;
              o_ready      <= 1'b1;
            end
          end
        end

        DRAIN: begin
          state   <= TRACEBACK;
          o_en_tb <= EN_ON;
        end

        TRACEBACK: begin
          if (i_tb_done) begin
            state   <= IDLE;
            o_en_tb <= 1'b0;
            o_busy  <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_extract_ctrl.sv
// Directed bench for rx_extract_ctrl with a behavioural radix-4 extractor
// (MSB-first 2-bit pointer sharing rst) attached to the FRAME_WORDS=2 instance.
`timescale 1ns/1ps
module tb_rx_extract_ctrl;
  import rx_extract_ctrl_pkg::*;

`ifdef RX_PREFETCH_EN
  localparam logic PREF = 1'b1;
`else
  localparam logic PREF = 1'b0;
`endif

  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FRAME_WORDS=2 instance
  logic        start, valid, tb_done;
  logic [15:0] data;
  logic        ready, en_ex, en_acs, fe, en_tb, busy;
  logic [15:0] word;
  logic [3:0]  idx;

  rx_extract_ctrl #(.DATA_W(16), .SYM_W(2), .FRAME_WORDS(2)) u_dut (
    .clk(clk), .rst(rst), .i_start(start), .i_data(data), .i_valid(valid),
    .o_ready(ready), .o_word(word), .o_en_extract(en_ex), .o_en_acs(en_acs),
    .o_sym_idx(idx), .o_frame_end(fe), .o_en_tb(en_tb), .i_tb_done(tb_done),
    .o_busy(busy)
  );

  // FRAME_WORDS=4 instance
  logic        s4, v4, done4;
  logic [15:0] d4, word4;
  logic        ready4, en4, acs4, fe4, tb4, busy4;
  logic [4:0]  idx4;

  rx_extract_ctrl #(.DATA_W(16), .SYM_W(2), .FRAME_WORDS(4)) u_dut4 (
    .clk(clk), .rst(rst), .i_start(s4), .i_data(d4), .i_valid(v4),
    .o_ready(ready4), .o_word(word4), .o_en_extract(en4), .o_en_acs(acs4),
    .o_sym_idx(idx4), .o_frame_end(fe4), .o_en_tb(tb4), .i_tb_done(done4),
    .o_busy(busy4)
  );

  // FRAME_WORDS=1 instance
  logic        s1, v1, done1;
  logic [15:0] d1, word1;
  logic        ready1, en1, acs1, fe1, tb1, busy1;
  logic [2:0]  idx1;

  rx_extract_ctrl #(.DATA_W(16), .SYM_W(2), .FRAME_WORDS(1)) u_dut1 (
    .clk(clk), .rst(rst), .i_start(s1), .i_data(d1), .i_valid(v1),
    .o_ready(ready1), .o_word(word1), .o_en_extract(en1), .o_en_acs(acs1),
    .o_sym_idx(idx1), .o_frame_end(fe1), .o_en_tb(tb1), .i_tb_done(done1),
    .o_busy(busy1)
  );

  // Extractor model: 2-bit MSB-first pointer, registered output.
  logic [3:0] ext_ptr;
  logic [1:0] ext_rx;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_ptr <= 4'd15;
      ext_rx  <= '0;
    end else if (en_ex) begin
      ext_rx  <= word[ext_ptr -: 2];
      ext_ptr <= ext_ptr - 4'd2;
    end
  end

  typedef struct {
    logic [1:0] rx;
    logic [3:0] idx;
    logic       fe;
  } sym_t;

  typedef struct {
    logic        start;
    logic        valid;
    logic        tb_done;
    logic [15:0] data;
    logic [5:0]  exp;   // {ready, en_extract, en_acs, frame_end, en_tb, busy}
  } vec_t;

  sym_t syms[$];
  vec_t vt[26];
  int   total;
  int   bad;
  int   en_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    sym_t s;
    @(posedge clk);
    #1;
    if (en_acs) begin
      s.rx  = ext_rx;
      s.idx = idx;
      s.fe  = fe;
      syms.push_back(s);
    end
    if (en_ex) en_cnt++;
  endtask

  task automatic send_word(input logic [15:0] d);
    logic got;
    logic ok;
    ok    = 1'b0;
    valid = 1'b1;
    data  = d;
    for (int i = 0; i < 64; i++) begin
      got = ready;
      step();
      if (got) begin
        ok = 1'b1;
        break;
      end
    end
    valid = 1'b0;
    check("accept", 32'(ok), 32'd1);
    for (int i = 0; i < 16 && en_ex; i++) step();
    check("en_drop", 32'(en_ex), 32'd0);
  endtask

  task automatic finish_tb();
    for (int i = 0; i < 8 && !en_tb; i++) step();
    check("tb_en", 32'(en_tb), 32'd1);
    tb_done = 1'b1;
    step();
    tb_done = 1'b0;
    check("tb_release", 32'({busy, en_tb, ready}), 32'd0);
  endtask

  function automatic vec_t mk(input logic s, input logic v, input logic t,
                              input logic [15:0] d, input logic [5:0] e);
    vec_t r;
    r.start = s; r.valid = v; r.tb_done = t; r.data = d; r.exp = e;
    return r;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_rx[16];
    logic [1:0] bp_rx[8];
    logic       bp_ok;
    logic       f;
    int         acc, run, fe_off, en_tot;
    logic       run_done;

    total = 0; bad = 0; en_cnt = 0;
    rst = 1'b0;
    start = 0; valid = 0; tb_done = 0; data = '0;
    s4 = 0; v4 = 0; done4 = 0; d4 = '0;
    s1 = 0; v1 = 0; done1 = 0; d1 = '0;

    exp_rx = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b11, 2'b10, 2'b00, 2'b01,
               2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b11, 2'b01, 2'b00};
    bp_rx  = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b01};

    vt[0] = mk(1, 0, 0, 16'h0, 6'b100001);
    vt[1] = mk(0, 1, 0, 16'hB4E1, {PREF, 5'b10001});
    vt[2] = mk(1, 0, 0, 16'h0, {PREF, 5'b11001});
    vt[3] = mk(0, !PREF, 0, 16'hFFFF, {PREF, 5'b11001});
    vt[4] = mk(0, 0, 1, 16'h0, {PREF, 5'b11001});
    for (int i = 5; i <= 8; i++) vt[i] = mk(0, 0, 0, 16'h0, {PREF, 5'b11001});
    vt[9]  = mk(0, 0, 0, 16'h0, 6'b101001);
    vt[10] = mk(0, 1, 0, 16'h1234, 6'b010001);
    for (int i = 11; i <= 17; i++) vt[i] = mk(0, 0, 0, 16'h0, 6'b011001);
    vt[18] = mk(0, 0, 0, 16'h0, 6'b001101);
    for (int i = 19; i <= 23; i++) vt[i] = mk(0, 0, 0, 16'h0, 6'b000011);
    vt[24] = mk(1, 0, 1, 16'h0, 6'b000000);
    vt[25] = mk(0, 0, 0, 16'h0, 6'b000000);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({ready, word, en_ex, en_acs, idx, fe, en_tb, busy}), 32'd0);
    check("reset_state", 32'(u_dut.state), 32'(IDLE));
    rst = 1'b1;

    // Word decode, ignored inputs, traceback handshake, start-with-done drop
    en_cnt = 0;
    syms.delete();
    for (int i = 0; i < 26; i++) begin
      start   = vt[i].start;
      valid   = vt[i].valid;
      tb_done = vt[i].tb_done;
      data    = vt[i].data;
      step();
      check($sformatf("vec[%0d]", i), 32'({ready, en_ex, en_acs, fe, en_tb, busy}), 32'(vt[i].exp));
    end
    start = 0; valid = 0; tb_done = 0;
    check("en_count", en_cnt, 16);
    check("sym_count", syms.size(), 16);
    for (int i = 0; i < 16 && i < syms.size(); i++) begin
      check($sformatf("rx[%0d]", i), 32'(syms[i].rx), 32'(exp_rx[i]));
      check($sformatf("idx[%0d]", i), 32'(syms[i].idx), i);
      check($sformatf("fe[%0d]", i), 32'(syms[i].fe), 32'(i == 15));
    end
    check("idle_after_drop", 32'(u_dut.state), 32'(IDLE));

    // Back-pressure in WAIT_WORD
    start = 1'b1;
    step();
    start = 1'b0;
    bp_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!(ready === 1'b1 && en_ex === 1'b0)) bp_ok = 1'b0;
    end
    check("backpressure_hold", 32'(bp_ok), 32'd1);
    syms.delete();
    send_word(16'h8421);
    check("bp_sym_count", syms.size(), 8);
    for (int i = 0; i < 8 && i < syms.size(); i++)
      check($sformatf("bp_rx[%0d]", i), 32'(syms[i].rx), 32'(bp_rx[i]));
    send_word(16'h0000);
    finish_tb();

    // Reset in the middle of extraction
    start = 1'b1;
    step();
    start = 1'b0;
    valid = 1'b1;
    data  = 16'h0F0F;
    step();
    valid = 1'b0;
    repeat (3) step();
    check("mid_sub_cnt", 32'(u_dut.sub_cnt), 32'd3);
    rst = 1'b0;
    #2;
    check("midrst_outputs", 32'({ready, word, en_ex, en_acs, idx, fe, en_tb, busy}), 32'd0);
    check("midrst_state", 32'(u_dut.state), 32'(IDLE));
    step();
    rst = 1'b1;
    syms.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    send_word(16'hFFFF);
    check("ff_sym_count", syms.size(), 8);
    for (int i = 0; i < 8 && i < syms.size(); i++) begin
      check($sformatf("ff_rx[%0d]", i), 32'(syms[i].rx), 32'd3);
      check($sformatf("ff_idx[%0d]", i), 32'(syms[i].idx), i);
    end
    send_word(16'h0000);
    finish_tb();

    // FRAME_WORDS=4 with i_valid held high
    s4 = 1'b1;
    step();
    s4 = 1'b0;
    v4 = 1'b1;
    d4 = 16'h1111;
    acc = -1; run = 0; run_done = 1'b0; fe_off = -1; en_tot = 0;
    for (int c = 0; c < 80; c++) begin
      f = ready4 & v4;
      step();
      if (f) begin
        if (acc < 0) acc = c;
        d4 = d4 + 16'h1111;
      end
      if (en4) en_tot++;
      if (en4 && !run_done) run++;
      else if (run > 0) run_done = 1'b1;
      if (fe4) begin
        fe_off = c - acc;
        break;
      end
    end
    v4 = 1'b0;
    check("fw4_en_run", run, PREF ? 32 : 8);
    check("fw4_en_total", en_tot, 32);
    // frame_end is seen right after the edge closing the last extract cycle
    check("fw4_fe_offset", fe_off, PREF ? 32 : 35);
    for (int i = 0; i < 8 && !tb4; i++) step();
    check("fw4_tb_en", 32'(tb4), 32'd1);
    done4 = 1'b1;
    step();
    done4 = 1'b0;
    check("fw4_idle", 32'({busy4, tb4}), 32'd0);

    // FRAME_WORDS=1 goes straight from EXTRACT to DRAIN
    s1 = 1'b1;
    step();
    s1 = 1'b0;
    v1 = 1'b1;
    d1 = 16'hA5A5;
    run = 0;
    for (int i = 0; i < 8 && !en1; i++) step();
    v1 = 1'b0;
    for (int i = 0; i < 16 && en1; i++) begin
      run++;
      step();
    end
    check("fw1_en_run", run, 8);
    check("fw1_drain", 32'(u_dut1.state), 32'(DRAIN));
    check("fw1_fe", 32'(fe1), 32'd1);
    step();
    check("fw1_tb_en", 32'({tb1, busy1}), 32'b11);
    done1 = 1'b1;
    step();
    done1 = 1'b0;
    check("fw1_idle", 32'({busy1, tb1, ready1}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
